// File: rtl/active_status_transmitter_pkg.sv
// rtl/active_status_transmitter_pkg.sv - header bytes, transmitter states and trailer checksum
package active_status_transmitter_pkg;

  // Header bytes the far-end control-register decoder synchronises on
  localparam logic [7:0] STATUS_HDR_BYTE1 = 8'h5A;
  localparam logic [7:0] STATUS_HDR_BYTE2 = 8'hC3;
  localparam logic [7:0] STATUS_HDR_BYTE3 = 8'h7E;

  typedef enum logic [3:0] {
    TX_IDLE    = 4'd0,
    TX_HDR1    = 4'd1,
    TX_HDR2    = 4'd2,
    TX_HDR3    = 4'd3,
    TX_PAYLOAD = 4'd4,
    TX_TRAILER = 4'd5
  } tx_state_t;

  function automatic logic [7:0] trailer_checksum(input logic [7:0] b1, input logic [7:0] b2,
                                                  input logic [7:0] b3, input logic [7:0] snap);
    return b1 ^ b2 ^ b3 ^ snap;
  endfunction

endpackage

// File: rtl/transfer_out_byte_handshake.sv
// rtl/transfer_out_byte_handshake.sv - SEND/DONE byte handshake with inter-byte gap and ack timeout
module transfer_out_byte_handshake
  import active_status_transmitter_pkg::*;
#(
  parameter int ACK_TIMEOUT = 1000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       load,
  input  logic [7:0] load_byte,
  input  logic       TRANSFER_OUT_DONE,
  output logic       TRANSFER_OUT_SEND,
  output logic [7:0] TRANSFER_OUT_BYTE,
  output logic       byte_accepted,
  output logic       byte_timeout,
  output logic       gap_ready
);

  localparam int CNT_W = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ACK_TIMEOUT);

  logic             done_reg;
  logic [CNT_W-1:0] tmo_cnt;

  // done_reg is the last sampled DONE, so a DONE already high when SEND rises counts as seen
  assign byte_accepted = TRANSFER_OUT_SEND & TRANSFER_OUT_DONE & ~done_reg;
  assign byte_timeout  = TRANSFER_OUT_SEND & ~byte_accepted & (ACK_TIMEOUT != 0)
                       & (tmo_cnt == CNT_W'(1));
  assign gap_ready     = ~TRANSFER_OUT_SEND & ~TRANSFER_OUT_DONE & done_reg;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      TRANSFER_OUT_SEND <= 1'b0;
      TRANSFER_OUT_BYTE <= 8'h00;
      done_reg          <= 1'b0;
      tmo_cnt           <= '0;
    end else begin
      done_reg <= TRANSFER_OUT_DONE;
      if (load) begin
        TRANSFER_OUT_SEND <= 1'b1;
        TRANSFER_OUT_BYTE <= load_byte;
        tmo_cnt           <= CNT_LOAD;
      end else if (byte_accepted) begin
        TRANSFER_OUT_SEND <= 1'b0;
        tmo_cnt           <= CNT_LOAD;
      end else if (byte_timeout) begin
        TRANSFER_OUT_SEND <= 1'b0;
      end else if (TRANSFER_OUT_SEND && (ACK_TIMEOUT != 0)) begin
        tmo_cnt <= tmo_cnt - CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/active_status_transmitter.sv
// rtl/active_status_transmitter.sv - 5-byte status frame serializer; STATUS_TX_CHECKSUM_EN selects checksum trailer
module active_status_transmitter
  import active_status_transmitter_pkg::*;
#(
  parameter logic [7:0] TRANSFER_STATUS_BYTE1 = STATUS_HDR_BYTE1,
  parameter logic [7:0] TRANSFER_STATUS_BYTE2 = STATUS_HDR_BYTE2,
  parameter logic [7:0] TRANSFER_STATUS_BYTE3 = STATUS_HDR_BYTE3,
  parameter int         ACK_TIMEOUT           = 1000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       SEND_REQUEST,
  input  logic [7:0] STATUS_REGISTER,
  input  logic       TRANSFER_OUT_DONE,
  output logic       TRANSFER_OUT_SEND,
  output logic [7:0] TRANSFER_OUT_BYTE,
  output logic       TX_BUSY,
  output logic       FRAME_SENT,
  output logic       TX_ERROR
);

  tx_state_t  state;
  logic       pending;
  logic [7:0] snapshot;
  logic [7:0] trailer_byte;
  logic [7:0] hs_byte;
  logic       hs_load;
  logic       start;
  logic       byte_accepted;
  logic       byte_timeout;
  logic       gap_ready;

`ifdef STATUS_TX_CHECKSUM_EN
  assign trailer_byte = trailer_checksum(TRANSFER_STATUS_BYTE1, TRANSFER_STATUS_BYTE2,
                                         TRANSFER_STATUS_BYTE3, snapshot);
`else
  assign trailer_byte = 8'h00;
`endif

  assign start   = (state == TX_IDLE) & (SEND_REQUEST | pending);
  assign hs_load = start | ((state != TX_IDLE) & gap_ready);

  always_comb begin
    hs_byte = TRANSFER_STATUS_BYTE1;
    case (state)
      TX_HDR2:    hs_byte = TRANSFER_STATUS_BYTE2;
      TX_HDR3:    hs_byte = TRANSFER_STATUS_BYTE3;
      TX_PAYLOAD: hs_byte = snapshot;
      TX_TRAILER: hs_byte = trailer_byte;
      default:    hs_byte = TRANSFER_STATUS_BYTE1;
    endcase
  end

  transfer_out_byte_handshake #(
    .ACK_TIMEOUT(ACK_TIMEOUT)
  ) u_handshake (
    .CLK              (CLK),
    .RST              (RST),
    .load             (hs_load),
    .load_byte        (hs_byte),
    .TRANSFER_OUT_DONE(TRANSFER_OUT_DONE),
    .TRANSFER_OUT_SEND(TRANSFER_OUT_SEND),
    .TRANSFER_OUT_BYTE(TRANSFER_OUT_BYTE),
    .byte_accepted    (byte_accepted),
    .byte_timeout     (byte_timeout),
    .gap_ready        (gap_ready)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state      <= TX_IDLE;
      pending    <= 1'b0;
      snapshot   <= 8'h00;
      TX_BUSY    <= 1'b0;
      FRAME_SENT <= 1'b0;
      TX_ERROR   <= 1'b0;
    end else begin
      FRAME_SENT <= 1'b0;
      TX_ERROR   <= 1'b0;
      if (start) begin
        snapshot <= STATUS_REGISTER;
        pending  <= 1'b0;
        state    <= TX_HDR1;
        TX_BUSY  <= 1'b1;
      end else begin
        // Requests during a frame coalesce into a single follow-up frame
        if (SEND_REQUEST) pending <= 1'b1;
        if (byte_accepted) begin
          if (state == TX_TRAILER) begin
            state      <= TX_IDLE;
            TX_BUSY    <= 1'b0;
            FRAME_SENT <= 1'b1;
          end else begin
            state <= tx_state_t'(state + 4'd1);
          end
        end else if (byte_timeout) begin
          state    <= TX_IDLE;
          TX_BUSY  <= 1'b0;
          TX_ERROR <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_active_status_transmitter.sv
// tb/tb_active_status_transmitter.sv - randomized bench for active_status_transmitter against a frame-level model
`timescale 1ns/1ps
module tb_active_status_transmitter;

  localparam int TMO = 20;
`ifdef STATUS_TX_CHECKSUM_EN
  localparam bit CKSUM_EN = 1'b1;
`else
  localparam bit CKSUM_EN = 1'b0;
`endif

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       SEND_REQUEST = 1'b0;
  logic [7:0] STATUS_REGISTER = 8'h00;
  logic       TRANSFER_OUT_DONE = 1'b0;
  logic       TRANSFER_OUT_SEND;
  logic [7:0] TRANSFER_OUT_BYTE;
  logic       TX_BUSY, FRAME_SENT, TX_ERROR;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 CLK = ~CLK;

  active_status_transmitter #(.ACK_TIMEOUT(TMO)) dut (
    .CLK(CLK), .RST(RST), .SEND_REQUEST(SEND_REQUEST), .STATUS_REGISTER(STATUS_REGISTER),
    .TRANSFER_OUT_DONE(TRANSFER_OUT_DONE), .TRANSFER_OUT_SEND(TRANSFER_OUT_SEND),
    .TRANSFER_OUT_BYTE(TRANSFER_OUT_BYTE), .TX_BUSY(TX_BUSY), .FRAME_SENT(FRAME_SENT),
    .TX_ERROR(TX_ERROR)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] exp_trailer(input logic [7:0] p);
    return CKSUM_EN ? (8'h5A ^ 8'hC3 ^ 8'h7E ^ p) : 8'h00;
  endfunction

  // Frame-level model: which byte of which frame is on offer, and how long it has waited
  bit         m_busy, m_send, m_gap, m_pending, m_prev_d, m_sent, m_err;
  int         m_idx, m_left;
  logic [7:0] m_frame [5];
  logic [7:0] m_byte;

  always @(posedge CLK) begin
    if (!RST) begin
      m_busy = 0; m_send = 0; m_gap = 0; m_pending = 0; m_prev_d = 0;
      m_sent = 0; m_err = 0; m_idx = 0; m_left = 0; m_byte = 8'h00;
    end else begin
      bit acc, tmo;
      acc = m_send && TRANSFER_OUT_DONE && !m_prev_d;
      tmo = m_send && !acc && (TMO != 0) && (m_left == 1);
      m_sent = 0;
      m_err  = 0;
      if (!m_busy && (SEND_REQUEST || m_pending)) begin
        m_frame[0] = 8'h5A; m_frame[1] = 8'hC3; m_frame[2] = 8'h7E;
        m_frame[3] = STATUS_REGISTER; m_frame[4] = exp_trailer(STATUS_REGISTER);
        m_idx = 0; m_send = 1; m_byte = m_frame[0]; m_left = TMO;
        m_busy = 1; m_pending = 0; m_gap = 0;
      end else begin
        if (SEND_REQUEST && m_busy) m_pending = 1;
        if (m_busy) begin
          if (acc) begin
            m_send = 0;
            if (m_idx == 4) begin m_busy = 0; m_sent = 1; end
            else begin m_idx++; m_gap = 1; end
          end else if (tmo) begin
            m_send = 0; m_busy = 0; m_err = 1; m_gap = 0;
          end else if (m_send) begin
            m_left--;
          end else if (m_gap && !TRANSFER_OUT_DONE && m_prev_d) begin
            m_send = 1; m_byte = m_frame[m_idx]; m_left = TMO; m_gap = 0;
          end
        end
      end
      m_prev_d = TRANSFER_OUT_DONE;
    end
  end

  // Channel-side view: accepted bytes, a loopback decoder, and pulse counters
  logic [7:0] got [$];
  logic [7:0] ctrl_reg = 8'h00;
  int         dec_cnt = 0;
  int         n_sent = 0, n_err = 0, n_send_hi = 0;
  logic       s_prev = 1'b0, d_prev = 1'b0;
  logic [7:0] b_prev = 8'h00;

  always @(posedge CLK) begin
    #1;
    chk("send", 32'(TRANSFER_OUT_SEND), 32'(m_send));
    chk("busy", 32'(TX_BUSY), 32'(m_busy));
    chk("frame_sent", 32'(FRAME_SENT), 32'(m_sent));
    chk("tx_error", 32'(TX_ERROR), 32'(m_err));
    if (m_send) chk("byte", 32'(TRANSFER_OUT_BYTE), 32'(m_byte));
    if (RST && s_prev && TRANSFER_OUT_DONE && !d_prev) begin
      got.push_back(b_prev);
      case (dec_cnt)
        0: dec_cnt = (b_prev == 8'h5A) ? 1 : 0;
        1: dec_cnt = (b_prev == 8'hC3) ? 2 : ((b_prev == 8'h5A) ? 1 : 0);
        2: dec_cnt = (b_prev == 8'h7E) ? 3 : ((b_prev == 8'h5A) ? 1 : 0);
        3: begin ctrl_reg = b_prev; dec_cnt = 4; end
        default: dec_cnt = 0;
      endcase
    end
    if (FRAME_SENT) n_sent++;
    if (TX_ERROR) n_err++;
    if (TRANSFER_OUT_SEND) n_send_hi++;
    s_prev = TRANSFER_OUT_SEND;
    b_prev = TRANSFER_OUT_BYTE;
    d_prev = TRANSFER_OUT_DONE;
    if (!RST) begin d_prev = 1'b0; dec_cnt = 0; end
  end

  // Far-end responder: either a forced DONE level or an automatic ack after a delay
  bit auto_ack = 0, force_done = 0, rand_ack = 0;
  int ack_dly = 3, hold = 1, wcnt = 0, hcnt = 0;

  always @(negedge CLK) begin
    if (!auto_ack) begin
      TRANSFER_OUT_DONE = force_done;
    end else if (TRANSFER_OUT_DONE) begin
      if (hcnt > 1) hcnt--;
      else TRANSFER_OUT_DONE = 1'b0;
    end else if (TRANSFER_OUT_SEND) begin
      wcnt++;
      if (wcnt >= ack_dly) begin
        TRANSFER_OUT_DONE = 1'b1;
        hcnt = hold;
        wcnt = 0;
        if (rand_ack) begin
          ack_dly = $urandom_range(1, 4);
          hold    = $urandom_range(1, 3);
        end
      end
    end else begin
      wcnt = 0;
    end
  end

  task automatic req_pulse();
    @(negedge CLK) SEND_REQUEST = 1'b1;
    @(negedge CLK) SEND_REQUEST = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    @(negedge CLK);
    while ((TX_BUSY || m_busy || m_pending) && k < budget) begin
      @(negedge CLK);
      k++;
    end
    chk("idle_wait", 32'(TX_BUSY), 32'd0);
  endtask

  initial begin
    repeat (3) @(negedge CLK);
    chk("rst_send", 32'(TRANSFER_OUT_SEND), 0);
    chk("rst_byte", 32'(TRANSFER_OUT_BYTE), 0);
    chk("rst_busy", 32'(TX_BUSY), 0);
    chk("rst_frame_sent", 32'(FRAME_SENT), 0);
    chk("rst_tx_error", 32'(TX_ERROR), 0);
    RST = 1'b1;

    // Basic frame, ack three cycles after SEND
    auto_ack = 1; ack_dly = 3; hold = 1;
    STATUS_REGISTER = 8'hA5;
    got.delete(); n_sent = 0;
    req_pulse();
    wait_idle(200);
    chk("a_len", 32'(got.size()), 5);
    if (got.size() == 5) begin
      chk("a_b0", 32'(got[0]), 32'h5A);
      chk("a_b1", 32'(got[1]), 32'hC3);
      chk("a_b2", 32'(got[2]), 32'h7E);
      chk("a_b3", 32'(got[3]), 32'hA5);
      chk("a_b4", 32'(got[4]), CKSUM_EN ? 32'h42 : 32'h00);
    end
    chk("a_sent", 32'(n_sent), 1);
    chk("a_ctrl", 32'(ctrl_reg), 32'hA5);

    // Loopback into the decoder
    STATUS_REGISTER = 8'h3C;
    req_pulse();
    wait_idle(200);
    chk("loop_ctrl", 32'(ctrl_reg), 32'h3C);

    // Four requests during a frame coalesce into one follow-up frame
    n_sent = 0;
    STATUS_REGISTER = 8'h11;
    req_pulse();
    for (int i = 0; i < 4; i++) begin
      STATUS_REGISTER = 8'($urandom);
      req_pulse();
    end
    STATUS_REGISTER = 8'h77;
    wait_idle(400);
    repeat (20) @(negedge CLK);
    chk("coal_sent", 32'(n_sent), 2);
    chk("coal_ctrl", 32'(ctrl_reg), 32'h77);

    // No ack at all: timeout abort
    auto_ack = 0; force_done = 0;
    repeat (2) @(negedge CLK);
    n_err = 0; n_sent = 0; n_send_hi = 0;
    req_pulse();
    wait_idle(200);
    chk("tmo_send_cycles", 32'(n_send_hi), TMO);
    chk("tmo_err", 32'(n_err), 1);
    chk("tmo_sent", 32'(n_sent), 0);

    // Reset while the payload byte is on offer
    auto_ack = 1; ack_dly = 3; hold = 1;
    STATUS_REGISTER = 8'hC9;
    req_pulse();
    for (int k = 0; k < 200 && !(m_send && m_idx == 3); k++) @(negedge CLK);
    chk("rst_reach_payload", 32'(TRANSFER_OUT_BYTE), 32'hC9);
    RST = 1'b0;
    #1;
    chk("mid_rst_send", 32'(TRANSFER_OUT_SEND), 0);
    chk("mid_rst_byte", 32'(TRANSFER_OUT_BYTE), 0);
    chk("mid_rst_busy", 32'(TX_BUSY), 0);
    chk("mid_rst_frame_sent", 32'(FRAME_SENT), 0);
    chk("mid_rst_tx_error", 32'(TX_ERROR), 0);
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    got.delete();
    STATUS_REGISTER = 8'h5B;
    req_pulse();
    wait_idle(200);
    chk("post_rst_len", 32'(got.size()), 5);
    if (got.size() == 5) begin
      chk("post_rst_b0", 32'(got[0]), 32'h5A);
      chk("post_rst_b3", 32'(got[3]), 32'h5B);
    end

    // DONE already high when the request arrives
    auto_ack = 0; force_done = 1;
    repeat (3) @(negedge CLK);
    got.delete();
    req_pulse();
    repeat (6) @(negedge CLK);
    chk("stale_send_held", 32'(TRANSFER_OUT_SEND), 1);
    chk("stale_not_taken", 32'(got.size()), 0);
    force_done = 0;
    repeat (2) @(negedge CLK);
    force_done = 1;
    repeat (2) @(negedge CLK);
    chk("stale_taken", 32'(got.size()), 1);
    if (got.size() >= 1) chk("stale_b0", 32'(got[0]), 32'h5A);
    hcnt = 1; ack_dly = 2; auto_ack = 1;
    wait_idle(200);
    chk("stale_len", 32'(got.size()), 5);

    // Randomized traffic with occasional silent channel periods
    n_sent = 0;
    rand_ack = 1;
    for (int c = 0; c < 3000; c++) begin
      @(negedge CLK);
      SEND_REQUEST = ($urandom_range(0, 9) == 0);
      STATUS_REGISTER = 8'($urandom);
      if ((c % 500) == 400) begin auto_ack = 0; force_done = 0; end
      if ((c % 500) == 450) begin hcnt = 1; auto_ack = 1; end
    end
    SEND_REQUEST = 1'b0;
    auto_ack = 1;
    wait_idle(400);
    chk("rand_frames_seen", 32'(n_sent != 0), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
